// File: rtl/qmult_pkg.sv
// rtl/qmult_pkg.sv - shared constants and product type for qmult (latency follows QMULT_INPUT_REG_EN)
package qmult_pkg;

  localparam int PRODUCT_W = 32;

`ifdef QMULT_INPUT_REG_EN
  localparam int LATENCY = 2;
`else
  localparam int LATENCY = 1;
`endif

  typedef logic signed [PRODUCT_W-1:0] product_t;

endpackage

// File: rtl/qmult_core.sv
// rtl/qmult_core.sv - combinational signed N x N multiply, sign-extended to PRODUCT_W bits
module qmult_core
  import qmult_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] multiplicand,
  input  logic [N-1:0] multiplier,
  output product_t     product
);

  // Widen both operands first so the multiply is exact at 2N bits.
  logic signed [2*N-1:0] a_ext;
  logic signed [2*N-1:0] b_ext;
  logic signed [2*N-1:0] p_full;

  assign a_ext   = (2*N)'($signed(multiplicand));
  assign b_ext   = (2*N)'($signed(multiplier));
  assign p_full  = a_ext * b_ext;
  assign product = PRODUCT_W'(p_full);

endmodule

// File: rtl/qmult.sv
// rtl/qmult.sv - pipelined signed multiplier top; QMULT_INPUT_REG_EN adds an input register stage
module qmult
  import qmult_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 input_vld,
  input  logic [N-1:0]         multiplicand_din,
  input  logic [N-1:0]         multiplier_din,
  output logic [PRODUCT_W-1:0] product_dout,
  output logic                 product_dout_vld,
  output logic                 product_end
);

  logic         mul_vld;
  logic [N-1:0] mul_a;
  logic [N-1:0] mul_b;
  product_t     prod;

`ifdef QMULT_INPUT_REG_EN
  logic         vld_q;
  logic [N-1:0] mcand_q;
  logic [N-1:0] mplier_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      vld_q    <= input_vld;
      mcand_q  <= multiplicand_din;
      mplier_q <= multiplier_din;
    end
  end

  assign mul_vld = vld_q;
  assign mul_a   = mcand_q;
  assign mul_b   = mplier_q;
`else
  assign mul_vld = input_vld;
  assign mul_a   = multiplicand_din;
  assign mul_b   = multiplier_din;
`endif

  qmult_core #(.N(N)) u_core (
    .multiplicand (mul_a),
    .multiplier   (mul_b),
    .product      (prod)
  );

  // End flag looks one stage ahead: the burst ends when the next output will be invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      product_dout     <= '0;
      product_dout_vld <= 1'b0;
      product_end      <= 1'b0;
    end else begin
      product_dout     <= mul_vld ? prod : '0;
      product_dout_vld <= mul_vld;
      product_end      <= product_dout_vld & ~mul_vld;
    end
  end

endmodule

// File: tb/tb_qmult.sv
// tb/tb_qmult.sv - randomized self-checking bench for qmult against a cycle-history reference model
module tb_qmult;

`ifdef QMULT_INPUT_REG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int N     = 16;
  localparam int MAX_C = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        input_vld;
  logic [15:0] multiplicand_din;
  logic [15:0] multiplier_din;
  logic [31:0] product_dout;
  logic        product_dout_vld;
  logic        product_end;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit r_hist [MAX_C];
  bit v_hist [MAX_C];
  int p_hist [MAX_C];

  always #5 clk = ~clk;

  qmult #(.N(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .input_vld        (input_vld),
    .multiplicand_din (multiplicand_din),
    .multiplier_din   (multiplier_din),
    .product_dout     (product_dout),
    .product_dout_vld (product_dout_vld),
    .product_end      (product_end)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, cyc, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // Output k is the sample taken L-1 edges earlier, provided no reset edge intervened.
  function automatic bit exp_vld(input int k);
    if (k - L + 1 < 0) return 1'b0;
    for (int j = k - L + 1; j <= k; j++)
      if (!r_hist[j]) return 1'b0;
    return v_hist[k - L + 1];
  endfunction

  function automatic int exp_prod(input int k);
    return exp_vld(k) ? p_hist[k - L + 1] : 0;
  endfunction

  function automatic bit exp_end(input int k);
    if (k < 1) return 1'b0;
    return r_hist[k] && exp_vld(k - 1) && !exp_vld(k);
  endfunction

  task automatic step(input bit r, input bit v, input int a, input int b);
    logic [31:0] a32, b32;
    @(negedge clk);
    a32 = a;
    b32 = b;
    rst_n            = r;
    input_vld        = v;
    multiplicand_din = a32[15:0];
    multiplier_din   = b32[15:0];
    @(posedge clk);
    r_hist[cyc] = r;
    v_hist[cyc] = v;
    p_hist[cyc] = a * b;
    #1;
    check("model_vld",  {31'd0, product_dout_vld}, {31'd0, exp_vld(cyc)});
    check("model_prod", product_dout, exp_prod(cyc));
    check("model_end",  {31'd0, product_end}, {31'd0, exp_end(cyc)});
    cyc++;
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic idle();
    step(1'b1, 1'b0, rnd_op(), rnd_op());
  endtask

  // Isolated valid: product must appear exactly L cycles on, then a single end pulse.
  task automatic isolated(input string tag, input int a, input int b, input logic [31:0] want);
    step(1'b1, 1'b1, a, b);
    repeat (L - 1) begin
      check({tag, "_early_vld"}, {31'd0, product_dout_vld}, 32'd0);
      idle();
    end
    check({tag, "_prod"}, product_dout, want);
    check({tag, "_vld"}, {31'd0, product_dout_vld}, 32'd1);
    idle();
    check({tag, "_end"}, {31'd0, product_end}, 32'd1);
    check({tag, "_vld_off"}, {31'd0, product_dout_vld}, 32'd0);
    idle();
    check({tag, "_end_off"}, {31'd0, product_end}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    input_vld = 1'b0;
    multiplicand_din = '0;
    multiplier_din = '0;

    repeat (3) step(1'b0, 1'($urandom_range(0, 1)), rnd_op(), rnd_op());
    check("rst_prod", product_dout, 32'd0);
    check("rst_vld",  {31'd0, product_dout_vld}, 32'd0);
    check("rst_end",  {31'd0, product_end}, 32'd0);
    idle();

    isolated("iso_3x-5", 3, -5, 32'hFFFF_FFF1);

    step(1'b1, 1'b1, 1, 1);
    step(1'b1, 1'b1, 2, -2);
    step(1'b1, 1'b1, 127, 127);
    step(1'b1, 1'b1, -128, 2);
    repeat (L - 1) idle();
    check("burst_last", product_dout, -32'sd256);
    idle();
    check("burst_end", {31'd0, product_end}, 32'd1);
    repeat (2) idle();

    isolated("ext_mm", -32768, -32768, 32'd1073741824);
    isolated("ext_pm", 32767, -32768, -32'sd1073709056);

    for (int i = 0; i < 20; i++) begin
      idle();
      check("idle_prod", product_dout, 32'd0);
    end

    // Reset pulse in the middle of a five-valid burst.
    step(1'b1, 1'b1, 5, 6);
    step(1'b1, 1'b1, 7, 8);
    step(1'b0, 1'b1, 9, 10);
    check("mid_rst_vld", {31'd0, product_dout_vld}, 32'd0);
    check("mid_rst_end", {31'd0, product_end}, 32'd0);
    step(1'b1, 1'b1, 11, 12);
    step(1'b1, 1'b1, -13, 14);
    repeat (3) idle();
    isolated("post_rst", -7, 9, -32'sd63);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)), rnd_op(), rnd_op());
    repeat (3) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qmult.md
QMULT -- requirements
Module: qmult

Interface
REQ-001 Parameter N, default 16, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock for all sequential logic.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 input_vld  input  1  operand pair valid this cycle, active high.
REQ-005 multiplicand_din  input  N  signed two's-complement multiplicand.
REQ-006 multiplier_din  input  N  signed two's-complement multiplier.
REQ-007 product_dout  output  32  signed two's-complement product, sign-extended to 32 bits.
REQ-008 product_dout_vld  output  1  product_dout valid this cycle, active high.
REQ-009 product_end  output  1  one-cycle pulse marking the end of a valid product burst.

Function
REQ-010 The block SHALL compute product_dout = signed(multiplicand_din) * signed(multiplier_din), exact and without overflow, since 2N <= 32.
REQ-011 The 2N-bit product SHALL be sign-extended to 32 bits; no rounding, truncation or saturation.
REQ-012 Latency SHALL be L = 1 clock from an input_vld-qualified sample to its product_dout/product_dout_vld; L = 2 when QMULT_INPUT_REG_EN is defined.
REQ-013 product_dout_vld SHALL equal input_vld delayed by exactly L cycles.
REQ-014 Throughput SHALL be one product per clock; back-to-back valids SHALL produce back-to-back results in order.
REQ-015 When product_dout_vld is low, product_dout SHALL be driven to 0.
REQ-016 Operands sampled while input_vld is low SHALL be ignored; they SHALL NOT affect any output.
REQ-017 product_end SHALL be high for exactly one cycle: the cycle immediately after the cycle in which product_dout_vld was high and is about to go low.
REQ-017a Equivalently, product_end SHALL be registered as (previous product_dout_vld AND NOT current product_dout_vld).
REQ-018 A single isolated valid SHALL produce one product_dout_vld cycle followed by one product_end cycle.
REQ-019 Operand extremes SHALL be exact, e.g. N=16: -32768 * -32768 = 1073741824; -32768 * 32767 = -1073709056.

Reset
REQ-020 While rst_n is low at a rising clk edge, product_dout, product_dout_vld and product_end SHALL be 0 on the next cycle.
REQ-020a All pipeline registers SHALL also be cleared.
REQ-021 Reset asserted mid-burst SHALL discard all in-flight products.
REQ-021a No product_end pulse SHALL be generated for a burst truncated by reset.
REQ-022 The first valid accepted after reset release SHALL appear after exactly L cycles.

Configuration
REQ-023 The macro QMULT_INPUT_REG_EN SHALL control an input register stage.
REQ-023a When QMULT_INPUT_REG_EN is defined: operands and input_vld are registered before the multiplier, and L = 2.
REQ-023b When QMULT_INPUT_REG_EN is undefined: operands feed the multiplier directly, and L = 1.
REQ-023c Function SHALL be otherwise identical in both builds.

Structure
REQ-024 The shared package qmult_pkg SHALL hold the following, and only these:
- PRODUCT_W = 32;
- the latency constant derived from QMULT_INPUT_REG_EN;
- the signed product typedef.
REQ-025 One sub-module, qmult_core, SHALL implement the combinational signed N x N multiply with 32-bit sign extension.
REQ-025a The top level SHALL hold the pipeline, valid and end-flag logic.

Verification
REQ-026 Reset, then an isolated valid with 3 * -5 -> product_dout = -15 (0xFFFFFFF1) with vld high L cycles later, product_end high the following cycle.
REQ-027 Burst of 4 consecutive valids (1*1, 2*-2, 127*127, -128*2) -> results 1, -4, 16129, -256 in order on 4 consecutive vld cycles, a single product_end after the last one.
REQ-028 Extremes at N=16: -32768*-32768 and 32767*-32768 -> 1073741824 and -1073709056 exactly.
REQ-029 input_vld low with random operands -> product_dout = 0, product_dout_vld = 0, product_end = 0 throughout.
REQ-030 rst_n asserted for 1 cycle in the middle of a 5-valid burst -> outputs 0 from the next cycle, in-flight products discarded, no product_end pulse for the truncated burst, post-reset valid returns after L cycles.
REQ-031 Run REQ-026 to REQ-030 with QMULT_INPUT_REG_EN both defined and undefined; latency checked as 2 and 1 respectively.
